apb_master_ctrl: RTL

//  APB3/APB4 initiator (requester). Turns a single-outstanding valid/ready request port into
//  APB SETUP/ACCESS transfers toward the APB peripherals (watchdog, SPI, ...), honouring

---
 rtl/apb_master_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/apb_master_ctrl.sv
// APB3/APB4 requester: turns a single-outstanding valid/ready request into
// APB SETUP/ACCESS transfers, with PSLVERR reporting and a wait-state timeout.
module apb_master_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_strb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [3:0]            PSTRB,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int unsigned CNT_W   = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic [3:0]            pstrb_d;
  logic                  rsp_valid_d, rsp_error_d, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  // Only IDLE can take a new request; decode straight from the state flops.
  assign req_ready = (state_q == IDLE);

  // State register plus registered APB and response outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= 4'h0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_error   <= rsp_error_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

  // Next-state and next-output logic; transfer fields hold unless a request is accepted.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = 1'b0;
    penable_d     = 1'b0;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    pstrb_d       = PSTRB;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_error_d   = rsp_error;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          cnt_d    = '0;
          pwrite_d = req_write;
          paddr_d  = req_addr & ~ADDR_WIDTH'(3);
          pwdata_d = req_wdata;
          pstrb_d  = req_write ? req_strb : 4'h0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_error_d   = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!PWRITE && !PSLVERR) ? PRDATA : '0;
        end else begin
          if (TO_EN) cnt_d = cnt_q + CNT_W'(1);
          if (TO_EN && (cnt_q == CNT_W'(TO_LAST))) begin
            state_d       = IDLE;
            rsp_valid_d   = 1'b1;
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
          end else begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
